// File: rtl/track_cmd_scheduler_if.sv
// Signal bundle between the command decoders / player and track_cmd_scheduler.
// The master side drives commands and the ack; the scheduler is the slave.
interface track_cmd_scheduler_if;
    logic [2:0] BT_PREV;
    logic [2:0] BT_NEXT;
    logic       BT_UP;
    logic       BT_DOWN;
    logic       BTN_PREV;
    logic       BTN_NEXT;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       LOAD_ACK;
    logic [2:0] TRACK;
    logic       LOAD_REQ;
    logic [3:0] VOLUME;
    logic       BUSY;

    modport master (
        output BT_PREV, BT_NEXT, BT_UP, BT_DOWN,
        output BTN_PREV, BTN_NEXT, BTN_UP, BTN_DOWN, LOAD_ACK,
        input  TRACK, LOAD_REQ, VOLUME, BUSY
    );

    modport slave (
        input  BT_PREV, BT_NEXT, BT_UP, BT_DOWN,
        input  BTN_PREV, BTN_NEXT, BTN_UP, BTN_DOWN, LOAD_ACK,
        output TRACK, LOAD_REQ, VOLUME, BUSY
    );
endinterface

// File: rtl/track_cmd_scheduler.sv
// Arbitrates Bluetooth/button track steps into a four-phase load handshake and
// keeps a saturating volume level with hold-to-repeat.
module track_cmd_scheduler #(
    parameter int unsigned NUM_TRACKS  = 7,
    parameter int unsigned VOL_MAX     = 15,
    parameter int unsigned VOL_DEFAULT = 8,
    parameter int unsigned HOLD_CYCLES = 1_000_000
) (
    input logic                  CLK,
    input logic                  RST,
    track_cmd_scheduler_if.slave bus
);
    localparam int unsigned     RptW      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0]      LastTrack = 3'(NUM_TRACKS - 1);
    localparam logic [3:0]      VolMax    = 4'(VOL_MAX);
    localparam logic [3:0]      VolDef    = 4'(VOL_DEFAULT);
    localparam logic [RptW-1:0] RptLast   = RptW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStep, StReq, StRelease} state_e;

    state_e          state_q, state_d;
    logic [5:0]      bt_hist_q;
    logic            btn_prev_hist_q, btn_next_hist_q, up_hist_q, dn_hist_q;
    logic            bt_vld_q, bt_vld_d, btn_vld_q, btn_vld_d;
    logic [3:0]      bt_step_q, bt_step_d, btn_step_q, btn_step_d;
    logic [2:0]      cnt_q, cnt_d, target_q, target_d, track_q, track_d;
    logic            dir_q, dir_d, load_req_q, load_req_d, busy_q, busy_d;
    logic [3:0]      vol_q, vol_d;
    logic [RptW-1:0] rpt_q, rpt_d;

    logic [5:0] bt_cur;
    logic       bt_evt, btn_evt, btn_rise_n, btn_rise_p, up, dn, fire;
    logic [3:0] bt_step, btn_step, take;
    logic       take_vld;
    logic [2:0] take_mag, target_step;

    // Steps are kept as 4-bit two's complement, range -7..+7.
    always_comb begin
        bt_cur     = {bus.BT_PREV, bus.BT_NEXT};
        bt_evt     = (bt_cur != 6'd0) && (bt_cur != bt_hist_q);
        bt_step    = {1'b0, bus.BT_NEXT} - {1'b0, bus.BT_PREV};
        btn_rise_n = bus.BTN_NEXT & ~btn_next_hist_q;
        btn_rise_p = bus.BTN_PREV & ~btn_prev_hist_q;
        btn_evt    = btn_rise_n | btn_rise_p;
        btn_step   = {3'b000, btn_rise_n} - {3'b000, btn_rise_p};
    end

    always_comb begin
        state_d    = state_q;
        bt_vld_d   = bt_vld_q;
        bt_step_d  = bt_step_q;
        btn_vld_d  = btn_vld_q;
        btn_step_d = btn_step_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        target_d   = target_q;
        track_d    = track_q;
        load_req_d = load_req_q;
        take       = 4'd0;
        take_vld   = 1'b0;
        take_mag   = 3'd0;
        if (dir_q) begin
            target_step = (target_q == 3'd0) ? LastTrack : target_q - 3'd1;
        end else begin
            target_step = (target_q == LastTrack) ? 3'd0 : target_q + 3'd1;
        end

        case (state_q)
            StIdle: begin
                if (bt_vld_q) begin
                    take     = bt_step_q;
                    take_vld = 1'b1;
                    bt_vld_d = 1'b0;
                end else if (btn_vld_q) begin
                    take      = btn_step_q;
                    take_vld  = 1'b1;
                    btn_vld_d = 1'b0;
                end
                take_mag = take[3] ? 3'(4'd0 - take) : take[2:0];
                if (take_vld && (take != 4'd0)) begin
                    state_d  = StStep;
                    cnt_d    = take_mag;
                    dir_d    = take[3];
                    target_d = track_q;
                end
            end
            StStep: begin
                target_d = target_step;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d    = StReq;
                    track_d    = target_step;
                    load_req_d = 1'b1;
                end
            end
            StReq: begin
                if (bus.LOAD_ACK) begin
                    state_d    = StRelease;
                    load_req_d = 1'b0;
                end
            end
            StRelease: begin
                if (!bus.LOAD_ACK) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A fresh event wins over the slot being consumed in the same cycle.
        if (bt_evt) begin
            bt_vld_d  = 1'b1;
            bt_step_d = bt_step;
        end
        if (btn_evt) begin
            btn_vld_d  = 1'b1;
            btn_step_d = btn_step;
        end
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        up    = bus.BT_UP | bus.BTN_UP;
        dn    = bus.BT_DOWN | bus.BTN_DOWN;
        vol_d = vol_q;
        rpt_d = '0;
        fire  = 1'b0;
        if (up != dn) begin
            if ((up && !up_hist_q) || (dn && !dn_hist_q)) begin
                fire = 1'b1;
            end else if (rpt_q == RptLast) begin
                fire = 1'b1;
            end else begin
                rpt_d = rpt_q + RptW'(1);
            end
        end
        if (fire && up && (vol_q < VolMax)) vol_d = vol_q + 4'd1;
        if (fire && dn && (vol_q > 4'd0))   vol_d = vol_q - 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            bt_vld_q   <= 1'b0;
            bt_step_q  <= 4'd0;
            btn_vld_q  <= 1'b0;
            btn_step_q <= 4'd0;
            cnt_q      <= 3'd0;
            dir_q      <= 1'b0;
            target_q   <= 3'd0;
            track_q    <= 3'd0;
            load_req_q <= 1'b0;
            busy_q     <= 1'b0;
            vol_q      <= VolDef;
            rpt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bt_vld_q   <= bt_vld_d;
            bt_step_q  <= bt_step_d;
            btn_vld_q  <= btn_vld_d;
            btn_step_q <= btn_step_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            target_q   <= target_d;
            track_q    <= track_d;
            load_req_q <= load_req_d;
            busy_q     <= busy_d;
            vol_q      <= vol_d;
            rpt_q      <= rpt_d;
        end
        // History follows the inputs in reset too, so held levels raise no events.
        bt_hist_q       <= bt_cur;
        btn_prev_hist_q <= bus.BTN_PREV;
        btn_next_hist_q <= bus.BTN_NEXT;
        up_hist_q       <= up;
        dn_hist_q       <= dn;
    end

    assign bus.TRACK    = track_q;
    assign bus.LOAD_REQ = load_req_q;
    assign bus.VOLUME   = vol_q;
    assign bus.BUSY     = busy_q;
endmodule

// File: doc/track_cmd_scheduler.md
# track_cmd_scheduler

Sequences decoded playback commands into the mp3 player core. Accepts track-step and volume commands from the Bluetooth command decoder and the on-board buttons, and arbitrates between the two sources. Walks the track index with wrap-around, issues a four-phase load handshake to the player, and keeps a saturating volume level with hold-to-repeat. Sits between the command decoders and the track loader / volume datapath.

## Interface

**Parameters**
- `NUM_TRACKS`, default 7: number of tracks. Legal range 2..8. Indices run 0..NUM_TRACKS-1.
- `VOL_MAX`, default 15: upper volume limit. Legal range ≤ 15.
- `VOL_DEFAULT`, default 8: volume after reset.
- `HOLD_CYCLES`, default 1_000_000: repeat interval while a volume key is held. Minimum 2.

**Ports**
- `CLK` in 1: system clock. Single clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `BT_PREV` in 3: backward step count from the Bluetooth decoder (level).
- `BT_NEXT` in 3: forward step count from the Bluetooth decoder (level).
- `BT_UP`, `BT_DOWN` in 1 each: Bluetooth volume levels.
- `BTN_PREV`, `BTN_NEXT`, `BTN_UP`, `BTN_DOWN` in 1 each: debounced button levels. A track button means a step of 1.
- `LOAD_ACK` in 1: player acknowledge for the load handshake.
- `TRACK` out 3: current or target track index.
- `LOAD_REQ` out 1: request to the player to load `TRACK`.
- `VOLUME` out 4: volume level.
- `BUSY` out 1: track FSM is not in IDLE.

## Operation

**Event detection.** Every input is registered once; events come from comparing the registered value with the current value.
- A BT track event fires when {BT_PREV, BT_NEXT} becomes nonzero and differs from its previous value.
- Both fields are captured at that moment. Net step = BT_NEXT − BT_PREV, signed, range −7..+7.
- A BTN track event fires on the rising edge of BTN_NEXT (+1) or BTN_PREV (−1). If both rise together, net step = 0.

**Pending slots.** There is one pending slot per source. A new event from a source overwrites that source's slot, in any state.

**Track FSM.**
- IDLE:
  - If the BT slot is valid, go to STEP with the BT step and clear the BT slot. This takes priority.
  - Otherwise, if the BTN slot is valid, go to STEP with the BTN step and clear the BTN slot.
  - A net step of 0 clears the slot and stays in IDLE; no load is issued.
- STEP:
  - A counter is loaded with |step|.
  - Each cycle, the internal target moves ±1 with wrap: NUM_TRACKS−1 + 1 → 0, and 0 − 1 → NUM_TRACKS−1.
  - The counter decrements each cycle. When it reaches 0, go to REQ.
- REQ:
  - `TRACK` takes the target value on entry. `LOAD_REQ` = 1.
  - Stay until `LOAD_ACK` = 1, then go to RELEASE with `LOAD_REQ` = 0.
- RELEASE: wait for `LOAD_ACK` = 0, then go to IDLE.

**Volume.** Volume is handled independently of the track FSM.
- Up = BT_UP | BTN_UP. Down = BT_DOWN | BTN_DOWN.
- On the rising edge of up (down), volume increments (decrements), saturating at VOL_MAX (0).
- While the key is held, a repeat counter fires the same step every HOLD_CYCLES cycles.
- Up and down active together: no change, and the repeat counter is cleared.
- Releasing the key clears the repeat counter.

**Reset.** Applies in any state, including mid-handshake:
- `TRACK` = 0, `VOLUME` = VOL_DEFAULT, `LOAD_REQ` = 0, `BUSY` = 0.
- FSM goes to IDLE; both slots, the step counter and the repeat counter are cleared.
- The input history registers take the current inputs, so levels already held at reset release do not generate events.

## Timing

- Input change sampled at edge k: the slot is valid after edge k.
- IDLE → STEP at edge k+1.
- STEP lasts |step| cycles. REQ is entered and `LOAD_REQ` rises after edge k+1+|step|.
- Minimum event-to-`LOAD_REQ` latency is 3 cycles (|step| = 1).
- `LOAD_REQ` falls at the edge after `LOAD_ACK` is sampled high.
- IDLE is re-entered at the edge after `LOAD_ACK` is sampled low.
- `BUSY` is a registered decode of state: high from STEP entry through RELEASE exit.
- A queued slot is picked up at the first IDLE cycle, which gives 1 idle cycle between back-to-back loads.
- Volume changes 1 cycle after the sampled edge. Repeats occur every HOLD_CYCLES cycles after that.
- `TRACK` changes only on REQ entry and on reset. It is stable throughout a handshake.

## Test plan

1. Reset release → `TRACK`=0, `VOLUME`=8, `LOAD_REQ`=0, `BUSY`=0. Assert RST while in REQ → `LOAD_REQ`=0, `TRACK`=0, and no event is generated from the held inputs.
2. From `TRACK`=0, BT_NEXT 0→2. Player acks 3 cycles after `LOAD_REQ` and drops the ack 2 cycles later → `LOAD_REQ` rises 4 cycles after the input change with `TRACK`=2; `BUSY` clears after the ack drops.
3. Wrap with NUM_TRACKS=7. `TRACK`=6, BT_NEXT=3 → `TRACK`=2. `TRACK`=1, BT_PREV=4 → `TRACK`=4. BT_PREV=1 with BT_NEXT=1 → no `LOAD_REQ`.
4. BT_NEXT=1 and BTN_PREV rise in the same cycle at `TRACK`=0 → two handshakes: first `TRACK`=1, then `TRACK`=0. While the first handshake is busy, a second BTN_NEXT overwrites the BTN slot → the second load is `TRACK`=2.
5. Volume with HOLD_CYCLES=4. Hold BTN_UP for 40 cycles from 8 → volume saturates at 15 and stays there. Hold BT_DOWN plus BT_UP together → no change. Pulse DOWN 20 times → volume stops at 0.
6. `LOAD_ACK` held high for 10 cycles after `LOAD_REQ` falls → the FSM stays in RELEASE and a new BT event stays pending; the load starts only after the ack drops.
